// File: rtl/multi_cycle_control_unit_if.sv
// Control bundle between the multi-cycle sequencer (master) and the RV32I datapath (slave).
// Carries IR opcode and status inputs plus every enable and select the sequencer drives.
interface multi_cycle_control_unit_if;
    logic [6:0] opcode;
    logic       ecall_exit;
    logic       mem_ready;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic       pc_source;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       reg_write;
    logic [1:0] wb_sel;
    logic       is_halted;
    logic [1:0] halt_cause;

    modport master (
        input  opcode, ecall_exit, mem_ready,
        output i_or_d, mem_read, mem_write, ir_write, pc_write, pc_write_cond,
               pc_source, alu_src_a, alu_src_b, alu_op, reg_write, wb_sel,
               is_halted, halt_cause
    );

    modport slave (
        output opcode, ecall_exit, mem_ready,
        input  i_or_d, mem_read, mem_write, ir_write, pc_write, pc_write_cond,
               pc_source, alu_src_a, alu_src_b, alu_op, reg_write, wb_sel,
               is_halted, halt_cause
    );
endinterface

// File: rtl/multi_cycle_control_unit.sv
// IF/ID/EX/MEM/WB sequencer for the multi-cycle RV32I datapath over a shared memory
// with a ready handshake; halts on ecall exit, illegal opcode or memory timeout.
module multi_cycle_control_unit #(
    parameter int MAX_WAIT = 255
) (
    input logic                          clk,
    input logic                          reset,
    multi_cycle_control_unit_if.master   bus
);
    localparam logic [2:0] S_IF   = 3'd0;
    localparam logic [2:0] S_ID   = 3'd1;
    localparam logic [2:0] S_EX   = 3'd2;
    localparam logic [2:0] S_MEM  = 3'd3;
    localparam logic [2:0] S_WB   = 3'd4;
    localparam logic [2:0] S_HALT = 3'd5;

    localparam logic [6:0] OP_ARITH     = 7'b0110011;
    localparam logic [6:0] OP_ARITH_IMM = 7'b0010011;
    localparam logic [6:0] OP_LOAD      = 7'b0000011;
    localparam logic [6:0] OP_STORE     = 7'b0100011;
    localparam logic [6:0] OP_BRANCH    = 7'b1100011;
    localparam logic [6:0] OP_JAL       = 7'b1101111;
    localparam logic [6:0] OP_JALR      = 7'b1100111;
    localparam logic [6:0] OP_ECALL     = 7'b1110011;

    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    logic [2:0] state_q, state_d;
    logic [7:0] wait_q, wait_d;
    logic [1:0] cause_q, cause_d;
    logic       mem_wait;
    logic       is_load;

    assign is_load = (bus.opcode == OP_LOAD);

    always_comb begin
        state_d           = state_q;
        wait_d            = wait_q;
        cause_d           = cause_q;
        mem_wait          = 1'b0;
        bus.i_or_d        = 1'b0;
        bus.mem_read      = 1'b0;
        bus.mem_write     = 1'b0;
        bus.ir_write      = 1'b0;
        bus.pc_write      = 1'b0;
        bus.pc_write_cond = 1'b0;
        bus.pc_source     = 1'b0;
        bus.alu_src_a     = 2'd0;
        bus.alu_src_b     = 2'd0;
        bus.alu_op        = 2'd0;
        bus.reg_write     = 1'b0;
        bus.wb_sel        = 2'd0;
        // Reset gates every output combinationally so requests drop without a clock edge.
        if (!reset) begin
            case (state_q)
                S_IF: begin
                    mem_wait      = 1'b1;
                    bus.mem_read  = 1'b1;
                    bus.alu_src_b = 2'd1;
                    if (bus.mem_ready) begin
                        bus.ir_write = 1'b1;
                        bus.pc_write = 1'b1;
                        state_d      = S_ID;
                    end
                end
                S_ID: begin
                    bus.alu_src_a = 2'd1;
                    bus.alu_src_b = 2'd2;
                    case (bus.opcode)
                        OP_ARITH, OP_ARITH_IMM, OP_LOAD, OP_STORE,
                        OP_BRANCH, OP_JAL, OP_JALR: state_d = S_EX;
                        OP_ECALL: begin
                            if (bus.ecall_exit) begin
                                state_d = S_HALT;
                                cause_d = 2'd0;
                            end else begin
                                state_d = S_IF;
                            end
                        end
                        default: begin
                            state_d = S_HALT;
                            cause_d = 2'd1;
                        end
                    endcase
                end
                S_EX: begin
                    state_d = S_IF;
                    case (bus.opcode)
                        OP_ARITH: begin
                            bus.alu_src_a = 2'd2;
                            bus.alu_op    = 2'd2;
                            state_d       = S_WB;
                        end
                        OP_ARITH_IMM: begin
                            bus.alu_src_a = 2'd2;
                            bus.alu_src_b = 2'd2;
                            bus.alu_op    = 2'd2;
                            state_d       = S_WB;
                        end
                        OP_LOAD, OP_STORE: begin
                            bus.alu_src_a = 2'd2;
                            bus.alu_src_b = 2'd2;
                            state_d       = S_MEM;
                        end
                        OP_BRANCH: begin
                            bus.alu_src_a     = 2'd2;
                            bus.alu_op        = 2'd1;
                            bus.pc_write_cond = 1'b1;
                            bus.pc_source     = 1'b1;
                        end
                        OP_JAL: begin
                            bus.reg_write = 1'b1;
                            bus.wb_sel    = 2'd2;
                            bus.pc_write  = 1'b1;
                            bus.pc_source = 1'b1;
                        end
                        OP_JALR: begin
                            bus.alu_src_a = 2'd2;
                            bus.alu_src_b = 2'd2;
                            bus.reg_write = 1'b1;
                            bus.wb_sel    = 2'd2;
                            bus.pc_write  = 1'b1;
                        end
                        default: state_d = S_IF;
                    endcase
                end
                S_MEM: begin
                    mem_wait      = 1'b1;
                    bus.i_or_d    = 1'b1;
                    bus.mem_read  = is_load;
                    bus.mem_write = (bus.opcode == OP_STORE);
                    if (bus.mem_ready) begin
                        state_d = is_load ? S_WB : S_IF;
                    end
                end
                S_WB: begin
                    bus.reg_write = 1'b1;
                    bus.wb_sel    = is_load ? 2'd1 : 2'd0;
                    state_d       = S_IF;
                end
                S_HALT: state_d = S_HALT;
                default: state_d = S_IF;
            endcase

            // A ready on the last tolerated cycle still completes; otherwise time out.
            if (mem_wait) begin
                if (bus.mem_ready) begin
                    wait_d = 8'd0;
                end else if (wait_q == WAIT_LAST) begin
                    state_d = S_HALT;
                    cause_d = 2'd2;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IF;
            wait_q  <= 8'd0;
            cause_q <= 2'd0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            cause_q <= cause_d;
        end
    end

    assign bus.is_halted  = (state_q == S_HALT);
    assign bus.halt_cause = cause_q;
endmodule

// File: tb/tb_multi_cycle_control_unit.sv
// Bench for multi_cycle_control_unit: directed and random instructions compared
// cycle by cycle against an expected control trace built from the instruction rules.
module tb_multi_cycle_control_unit;
    localparam int MAXW = 255;

    localparam logic [6:0] OP_ADD   = 7'b0110011;
    localparam logic [6:0] OP_ADDI  = 7'b0010011;
    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_ECALL = 7'b1110011;

    typedef struct packed {
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       pc_write;
        logic       pc_write_cond;
        logic       pc_source;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       reg_write;
        logic [1:0] wb_sel;
        logic       is_halted;
        logic [1:0] halt_cause;
    } ctl_t;

    typedef struct packed {
        logic rdy;
        ctl_t c;
    } step_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    step_t trace[$];
    ctl_t  obs;

    multi_cycle_control_unit_if bus ();

    multi_cycle_control_unit #(.MAX_WAIT(MAXW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    assign obs = {bus.i_or_d, bus.mem_read, bus.mem_write, bus.ir_write, bus.pc_write,
                  bus.pc_write_cond, bus.pc_source, bus.alu_src_a, bus.alu_src_b,
                  bus.alu_op, bus.reg_write, bus.wb_sel, bus.is_halted, bus.halt_cause};

    task automatic check(input string tag, input ctl_t exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic rdy, input ctl_t c);
        step_t s;
        s.rdy = rdy;
        s.c   = c;
        trace.push_back(s);
    endtask

    // Memory phase: w stall cycles; MAXW or more means the request never completes.
    task automatic mem_phase(input int w, input ctl_t req, input ctl_t done, output bit to);
        int n;
        n  = (w >= MAXW) ? MAXW : w;
        to = (w >= MAXW);
        for (int k = 0; k < n; k++) push(1'b0, req);
        if (!to) push(1'b1, done);
    endtask

    task automatic halt_phase(input logic [1:0] cause);
        ctl_t c;
        c = '0;
        c.is_halted  = 1'b1;
        c.halt_cause = cause;
        for (int k = 0; k < 4; k++) push(1'($urandom_range(0, 1)), c);
    endtask

    // Expected per-cycle control trace of one instruction; halted reports an absorbing end.
    task automatic build(input logic [6:0] op, input logic ex, input int wif, input int wmem,
                         output bit halted);
        ctl_t c, d;
        bit   to;
        trace.delete();
        halted = 1'b0;
        c = '0; c.mem_read = 1'b1; c.alu_src_b = 2'd1;
        d = c;  d.ir_write = 1'b1; d.pc_write = 1'b1;
        mem_phase(wif, c, d, to);
        if (to) begin halt_phase(2'd2); halted = 1'b1; return; end
        c = '0; c.alu_src_a = 2'd1; c.alu_src_b = 2'd2;
        push(1'($urandom_range(0, 1)), c);
        c = '0;
        case (op)
            OP_ADD, OP_ADDI: begin
                c.alu_src_a = 2'd2;
                c.alu_src_b = (op == OP_ADDI) ? 2'd2 : 2'd0;
                c.alu_op    = 2'd2;
                push(1'($urandom_range(0, 1)), c);
                c = '0; c.reg_write = 1'b1;
                push(1'($urandom_range(0, 1)), c);
            end
            OP_LW, OP_SW: begin
                c.alu_src_a = 2'd2; c.alu_src_b = 2'd2;
                push(1'($urandom_range(0, 1)), c);
                c = '0; c.i_or_d = 1'b1;
                c.mem_read  = (op == OP_LW);
                c.mem_write = (op == OP_SW);
                mem_phase(wmem, c, c, to);
                if (to) begin halt_phase(2'd2); halted = 1'b1; return; end
                if (op == OP_LW) begin
                    c = '0; c.reg_write = 1'b1; c.wb_sel = 2'd1;
                    push(1'($urandom_range(0, 1)), c);
                end
            end
            OP_BEQ: begin
                c.alu_src_a = 2'd2; c.alu_op = 2'd1;
                c.pc_write_cond = 1'b1; c.pc_source = 1'b1;
                push(1'($urandom_range(0, 1)), c);
            end
            OP_JAL: begin
                c.reg_write = 1'b1; c.wb_sel = 2'd2; c.pc_write = 1'b1; c.pc_source = 1'b1;
                push(1'($urandom_range(0, 1)), c);
            end
            OP_JALR: begin
                c.alu_src_a = 2'd2; c.alu_src_b = 2'd2;
                c.reg_write = 1'b1; c.wb_sel = 2'd2; c.pc_write = 1'b1;
                push(1'($urandom_range(0, 1)), c);
            end
            OP_ECALL: begin
                if (ex) begin halt_phase(2'd0); halted = 1'b1; end
            end
            default: begin halt_phase(2'd1); halted = 1'b1; end
        endcase
    endtask

    // Called just after a falling edge; returns just after a falling edge.
    task automatic apply_reset(input string tag);
        #2 reset = 1'b1;
        #1 check(tag, ctl_t'(0));
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Plays up to limit cycles of the expected trace; returns 1 if it was cut short.
    task automatic run(input string tag, input logic [6:0] op, input logic ex, input int limit,
                       output bit cut);
        int n;
        step_t s;
        n = 0;
        while (trace.size() > 0 && n < limit) begin
            s = trace.pop_front();
            if (n == 0) begin bus.opcode = op; bus.ecall_exit = ex; end
            bus.mem_ready = s.rdy;
            #1 check(tag, s.c);
            @(negedge clk);
            n++;
        end
        cut = (trace.size() > 0);
    endtask

    task automatic instr(input string tag, input logic [6:0] op, input logic ex,
                         input int wif, input int wmem, input int limit);
        bit halted, cut;
        build(op, ex, wif, wmem, halted);
        run(tag, op, ex, limit, cut);
        if (halted || cut) apply_reset({tag, "_reset"});
    endtask

    initial begin
        logic [6:0] ops [12];
        logic [6:0] op;
        ops = '{OP_ADD, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_JAL, OP_JALR, OP_ECALL,
                7'b0000000, 7'b1111111, 7'b0110111, 7'b0010111};
        reset          = 1'b1;
        bus.opcode     = 7'd0;
        bus.ecall_exit = 1'b0;
        bus.mem_ready  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1 check("reset_state", ctl_t'(0));
        @(negedge clk);
        reset = 1'b0;

        // Reset dropped onto an outstanding fetch and onto an outstanding load.
        instr("mid_if", OP_ADD, 1'b0, 3, 0, 1);
        instr("mid_mem", OP_LW, 1'b0, 0, 5, 5);

        instr("add", OP_ADD, 1'b0, 0, 0, 1000);
        instr("lw_wait3", OP_LW, 1'b0, 0, 3, 1000);
        instr("beq", OP_BEQ, 1'b0, 0, 0, 1000);
        instr("jal", OP_JAL, 1'b0, 1, 0, 1000);
        instr("illegal", 7'b0000000, 1'b0, 0, 0, 1000);
        instr("ecall_cont", OP_ECALL, 1'b0, 0, 0, 1000);
        instr("sw_after_ecall", OP_SW, 1'b0, 0, 2, 1000);
        instr("ecall_exit", OP_ECALL, 1'b1, 0, 0, 1000);
        instr("if_ready_last", OP_ADDI, 1'b0, MAXW - 1, 0, 1000);
        instr("if_timeout", OP_ADD, 1'b0, MAXW, 0, 1000);
        instr("mem_ready_last", OP_SW, 1'b0, 0, MAXW - 1, 1000);
        instr("mem_timeout", OP_LW, 1'b0, 0, MAXW, 1000);

        for (int i = 0; i < 80; i++) begin
            op = ops[$urandom_range(0, 11)];
            instr("random", op, 1'($urandom_range(0, 1)), $urandom_range(0, 3),
                  $urandom_range(0, 3), ($urandom_range(0, 7) == 0) ? $urandom_range(1, 4) : 1000);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/multi_cycle_control_unit.md
Name: multi_cycle_control_unit

Overview:
- Sequencing FSM for the multi-cycle RV32I datapath.
- Replaces the single-cycle combinational control. Steps each instruction through IF/ID/EX/MEM/WB over a shared unified memory with a ready handshake.
- Drives PC/IR/ALUOut/MDR enables, operand muxes, ALU op class and write-back select.
- Opcodes are decoded with the shared opcodes.v macros. The immediate is formed by the existing immediate generator from the latched IR.

Parameters:
- MAX_WAIT, 255, memory-wait cycles tolerated before a timeout halt (8-bit wait counter).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- opcode  input  7  IR[6:0] of the latched instruction.
- ecall_exit  input  1  datapath flag: x17 == 10.
- mem_ready  input  1  memory completes the current request this cycle.
- i_or_d  output  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_read  output  1  memory read request.
- mem_write  output  1  memory write request.
- ir_write  output  1  latch memory data into IR; also copies PC into old_pc.
- pc_write  output  1  unconditional PC update.
- pc_write_cond  output  1  PC update if ALU branch-taken flag.
- pc_source  output  1  next-PC select: 0 = ALU result, 1 = ALUOut.
- alu_src_a  output  2  0 = PC, 1 = old_pc, 2 = rs1.
- alu_src_b  output  2  0 = rs2, 1 = const 4, 2 = immediate.
- alu_op  output  2  0 = add, 1 = branch compare, 2 = R/I-type funct decode.
- reg_write  output  1  register file write enable.
- wb_sel  output  2  0 = ALUOut, 1 = MDR, 2 = PC.
- is_halted  output  1  core halted (sticky).
- halt_cause  output  2  0 = ecall, 1 = illegal opcode, 2 = memory timeout.

Behaviour:
- States: IF, ID, EX, MEM, WB, HALT.
- Reset:
  - state = IF, wait counter = 0.
  - is_halted = 0, halt_cause = 0.
  - All outputs are Moore/Mealy-decoded from state; in reset all enables are 0.
- Defaults: every enable is 0 and every select is 0 unless listed below.
- IF:
  - mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=1, alu_op=0.
  - While !mem_ready: stay in IF, wait counter increments.
  - On mem_ready: ir_write=1, pc_write=1, pc_source=0 (PC <= PC+4), wait counter cleared, go to ID.
- ID:
  - alu_src_a=1, alu_src_b=2, alu_op=0 (ALUOut <= old_pc+imm).
  - Next state: EX for ARITHMETIC, ARITHMETIC_IMM, LOAD, STORE, BRANCH, JAL, JALR.
  - ECALL with ecall_exit=1: HALT, cause 0.
  - ECALL with ecall_exit=0: IF (no-op).
  - Any other opcode: HALT, cause 1.
- EX:
  - ARITHMETIC: alu_src_a=2, alu_src_b=0, alu_op=2, then WB.
  - ARITHMETIC_IMM: alu_src_a=2, alu_src_b=2, alu_op=2, then WB.
  - LOAD/STORE: alu_src_a=2, alu_src_b=2, alu_op=0, then MEM.
  - BRANCH: alu_src_a=2, alu_src_b=0, alu_op=1, pc_write_cond=1, pc_source=1, then IF.
  - JAL: reg_write=1, wb_sel=2, pc_write=1, pc_source=1, then IF.
  - JALR: alu_src_a=2, alu_src_b=2, alu_op=0, reg_write=1, wb_sel=2, pc_write=1, pc_source=0, then IF. The datapath clears bit 0.
- MEM:
  - i_or_d=1; mem_read=1 for LOAD, mem_write=1 for STORE. Requests are held stable until mem_ready.
  - On mem_ready: LOAD goes to WB, STORE goes to IF.
- WB:
  - reg_write=1; wb_sel=1 for LOAD, 0 for arithmetic. Then IF.
- Timeout: if the wait counter reaches MAX_WAIT in IF or MEM without mem_ready, go to HALT, cause 2.
  - mem_ready on that same cycle wins: no timeout.
- HALT:
  - Absorbing state: is_halted=1, all enables 0.
  - Only reset leaves HALT.
  - halt_cause is latched on entry.
- Reset mid-operation (including while a memory request is outstanding): all requests drop immediately (async), state returns to IF.
- Instruction latency, for zero-wait memory:
  - BRANCH/JAL/JALR: 3 cycles.
  - Arithmetic/STORE: 4 cycles.
  - LOAD: 5 cycles.
  - Each memory wait cycle adds 1.

Test Plan:
- Reset asserted mid-IF with mem_read=1 -> mem_read falls without a clock edge; after release, state=IF and is_halted=0.
- ADD x1,x2,x3 (opcode 0110011), mem_ready always 1 -> IF,ID,EX,WB in 4 cycles; reg_write=1 only in cycle 4, wb_sel=0.
- LW (0000011) with mem_ready held low 3 cycles in MEM -> mem_read/i_or_d=1 held steady for 4 cycles, then WB with wb_sel=1; total 8 cycles.
- BEQ (1100011) -> pc_write_cond=1, pc_source=1 in EX only; next state IF at cycle 4; reg_write never asserted.
- Opcode 0000000 -> HALT after ID with halt_cause=1. ECALL with ecall_exit=0 -> returns to IF; with ecall_exit=1 -> halt_cause=0.
- mem_ready stuck low in IF -> HALT after MAX_WAIT (255) cycles, halt_cause=2; mem_ready asserted on cycle 255 -> ID, no halt.
